// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, default frame length and
// the bit-count width helper used by both the responder and the master driver.
package spi_pkg;

    localparam int SPI_MAXLEN_DEF = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Width of a counter that must hold the values 0..maxlen inclusive.
    function automatic int cnt_w(input int maxlen);
        return $clog2(maxlen) + 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with single-cycle rise/fall
// pulses taken from the last two stages of the chain.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic sresetn,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    // One extra stage beyond the synchroniser depth serves as the edge-detect history.
    logic [SYNC_STAGES:0] sync_q;

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            sync_q <= {(SYNC_STAGES+1){RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], d_i};
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    assign fall_o = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];

endmodule

// File: rtl/spi_slv.sv
// SPI responder: oversampled SCLK/SS_N/MOSI, MSB-first shifting, one host word
// per frame through a holding register, received frame reported with its bit count.
module spi_slv
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN  = SPI_MAXLEN_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic                          SCLK,
    input  logic                          SS_N,
    input  logic                          MOSI,
    output logic                          MISO,
    output logic                          miso_oe,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_underrun,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [cnt_w(SPI_MAXLEN)-1:0]  rx_nbits,
    output logic                          rx_valid,
    output logic                          busy
);

    localparam int CW    = cnt_w(SPI_MAXLEN);
    localparam int FW    = $clog2(SYNC_STAGES + 2);
    localparam int FLUSH = SYNC_STAGES + 1;

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk(clk), .sresetn(sresetn), .d_i(SCLK),
        .lvl_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .sresetn(sresetn), .d_i(SS_N),
        .lvl_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .sresetn(sresetn), .d_i(MOSI),
        .lvl_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    logic [1:0]            state_q,    state_d;
    logic [CW-1:0]         cnt_q,      cnt_d;
    logic [SPI_MAXLEN-1:0] hold_q,     hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [SPI_MAXLEN-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_MAXLEN-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_MAXLEN-1:0] rx_data_q,  rx_data_d;
    logic [CW-1:0]         rx_nbits_q, rx_nbits_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  underrun_q, underrun_d;
    logic                  miso_q,     miso_d;
    logic                  oe_q,       oe_d;
    logic [FW-1:0]         flush_q,    flush_d;
    logic                  armed_q,    armed_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_nbits_d  = rx_nbits_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        miso_d      = miso_q;
        oe_d        = oe_q;
        flush_d     = flush_q;
        armed_d     = armed_q;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        // The synchronisers wake up reading "deselected"; a frame may only start once
        // they have flushed and SS_N has genuinely been seen high.
        if (flush_q != FW'(FLUSH)) begin
            flush_d = flush_q + FW'(1);
        end else if (ss_lvl) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d    = ST_ACTIVE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    oe_d       = 1'b1;
                    if (hold_full_q) begin
                        tx_shift_d  = hold_q;
                        miso_d      = hold_q[SPI_MAXLEN-1];
                        hold_full_d = 1'b0;
                    end else begin
                        tx_shift_d = '0;
                        miso_d     = 1'b0;
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_d = ST_DONE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end else if (ss_fall) begin
                    state_d = ST_ACTIVE;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[SPI_MAXLEN-2:0], mosi_lvl};
                    cnt_d      = (cnt_q == CW'(SPI_MAXLEN)) ? cnt_q : cnt_q + CW'(1);
                end else if (sclk_fall && cnt_q != '0) begin
                    tx_shift_d = tx_shift_q << 1;
                    miso_d     = tx_shift_q[SPI_MAXLEN-2];
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                tx_shift_d = '0;
                if (cnt_q != '0) begin
                    rx_data_d  = rx_shift_q;
                    rx_nbits_d = cnt_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                miso_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_nbits_q  <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_nbits_q  <= rx_nbits_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
        end
    end

    assign MISO        = miso_q;
    assign miso_oe     = oe_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = underrun_q;
    assign rx_data     = rx_data_q;
    assign rx_nbits    = rx_nbits_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slv.sv
// Bench for spi_slv: SPI master driving 100-clk SCLK periods, randomized frames
// checked against a bit-level reference model of the responder.
module tb_spi_slv;

    localparam int W  = 32;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          sresetn = 1'b0;
    logic          sclk = 1'b1;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso, miso_oe, tx_ready, tx_underrun, rx_valid, busy;
    logic          tx_valid = 1'b0;
    logic [W-1:0]  tx_data = '0;
    logic [W-1:0]  rx_data;
    logic [CW-1:0] rx_nbits;

    always #5 clk = ~clk;

    spi_slv #(.SPI_MAXLEN(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .sresetn(sresetn), .SCLK(sclk), .SS_N(ss_n), .MOSI(mosi),
        .MISO(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun), .rx_data(rx_data),
        .rx_nbits(rx_nbits), .rx_valid(rx_valid), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    int           rxv_cnt = 0;
    int           und_cnt = 0;
    logic [W-1:0] mon_rx  = '0;
    int           mon_nb  = 0;

    // Reference model of the holding register.
    bit           hold_m = 1'b0;
    logic [W-1:0] hold_word_m = '0;

    logic [63:0]  miso_cap;
    int           oe_bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
            mon_rx = rx_data;
            mon_nb = int'(rx_nbits);
        end
        if (tx_underrun === 1'b1) und_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_load(input logic [W-1:0] w);
        @(negedge clk);
        check_eq("tx_ready_at_load", tx_ready, 1'b1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid    = 1'b0;
        hold_m      = 1'b1;
        hold_word_m = w;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},     miso, 0);
        check_eq({tag, "_miso_oe"},  miso_oe, 0);
        check_eq({tag, "_tx_ready"}, tx_ready, 1);
        check_eq({tag, "_underrun"}, tx_underrun, 0);
        check_eq({tag, "_rx_data"},  rx_data, 0);
        check_eq({tag, "_rx_nbits"}, rx_nbits, 0);
        check_eq({tag, "_rx_valid"}, rx_valid, 0);
        check_eq({tag, "_busy"},     busy, 0);
    endtask

    // Master side: MOSI changes on SCLK fall, MISO sampled just before SCLK rise.
    task automatic run_frame(input int nbits, input logic [63:0] mw,
                             input int load_at, input logic [W-1:0] lw);
        ss_n = 1'b0;
        wait_clk(50);
        miso_cap = '0;
        oe_bad   = 0;
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = mw[nbits-1-i];
            wait_clk(48);
            if (i == load_at) host_load(lw);
            else wait_clk(2);
            miso_cap = {miso_cap[62:0], miso};
            if (miso_oe !== 1'b1) oe_bad++;
            sclk = 1'b1;
            wait_clk(50);
        end
        wait_clk(10);
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_clk(30);
    endtask

    task automatic do_frame(input string tag, input int nbits, input logic [63:0] mw,
                            input int load_at, input logic [W-1:0] lw);
        bit           loaded;
        logic [W-1:0] tw;
        logic [63:0]  exp_miso;
        logic [W-1:0] exp_rx;
        int           exp_nb, rx0, u0;

        check_eq({tag, "_tx_ready_pre"}, tx_ready, !hold_m);
        loaded = hold_m;
        tw     = hold_word_m;
        hold_m = 1'b0;
        rx0    = rxv_cnt;
        u0     = und_cnt;

        exp_miso = '0;
        for (int i = 0; i < nbits; i++) begin
            bit b;
            b = 1'b0;
            if (loaded && i < W) b = tw[W-1-i];
            exp_miso = {exp_miso[62:0], b};
        end
        exp_nb = (nbits > W) ? W : nbits;
        exp_rx = (nbits >= W) ? mw[W-1:0] : W'(mw & ((64'd1 << nbits) - 64'd1));

        run_frame(nbits, mw, load_at, lw);

        check_eq({tag, "_miso_bits"}, miso_cap, exp_miso);
        check_eq({tag, "_oe_during"}, oe_bad, 0);
        check_eq({tag, "_underrun"},  und_cnt - u0, loaded ? 0 : 1);
        check_eq({tag, "_rx_pulses"}, rxv_cnt - rx0, (nbits > 0) ? 1 : 0);
        if (nbits > 0) begin
            check_eq({tag, "_rx_data"},  mon_rx, exp_rx);
            check_eq({tag, "_rx_nbits"}, mon_nb, exp_nb);
        end
        check_eq({tag, "_tx_ready_post"}, tx_ready, !hold_m);
        check_eq({tag, "_oe_after"},  miso_oe, 0);
        check_eq({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int rx0;
        int nb;
        int la;
        logic [63:0] mw;

        wait_clk(3);
        check_reset_outputs("reset");
        @(negedge clk);
        sresetn = 1'b1;
        wait_clk(10);

        host_load(32'hA500_0000);
        do_frame("t1", 8, 64'h3C, -1, '0);

        do_frame("t2", 32, 64'hDEAD_BEEF, -1, '0);

        host_load($urandom);
        do_frame("t3", 40, 64'hFF_1234_5678, -1, '0);

        host_load($urandom);
        do_frame("t4a", 16, {32'h0, $urandom}, 5, 32'h8000_0000);
        do_frame("t4b", 12, {32'h0, $urandom}, -1, '0);

        // Reset mid-frame with SS_N still asserted.
        host_load($urandom);
        rx0  = rxv_cnt;
        ss_n = 1'b0;
        wait_clk(50);
        for (int i = 0; i < 5; i++) begin
            sclk = 1'b0;
            mosi = 1'($urandom);
            wait_clk(50);
            sclk = 1'b1;
            wait_clk(50);
        end
        #3 sresetn = 1'b0;
        #1 check_reset_outputs("t5_reset");
        hold_m = 1'b0;
        wait_clk(5);
        sresetn = 1'b1;
        wait_clk(30);
        check_eq("t5_idle_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b0;
            wait_clk(50);
            sclk = 1'b1;
            wait_clk(50);
        end
        check_eq("t5_stuck_busy", busy, 0);
        check_eq("t5_stuck_oe", miso_oe, 0);
        check_eq("t5_no_rx_valid", rxv_cnt - rx0, 0);
        ss_n = 1'b1;
        wait_clk(30);
        host_load($urandom);
        do_frame("t5c", 8, {56'h0, 8'($urandom)}, -1, '0);

        host_load($urandom);
        do_frame("t6", 0, 64'h0, -1, '0);

        for (int k = 0; k < 12; k++) begin
            nb = $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 1 && !hold_m) host_load($urandom);
            la = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
            mw = {$urandom, $urandom};
            do_frame($sformatf("rnd%0d", k), nb, mw, la, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
